// File: rtl/ship_input_pkg.sv
// Shared types and defaults for the ship input conditioner.
// Optional auto-repeat is enabled by defining SHIP_AUTO_REPEAT_EN.
package ship_input_pkg;

    localparam int CNT_W               = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 8;
    localparam int DEF_REPEAT_PERIOD   = 4;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        DISARMING = 2'd3
    } key_state_t;

    // Saturating increment so a key held for a very long time never wraps the count
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One pushbutton: 2-flop synchronizer, debounce FSM and (with SHIP_AUTO_REPEAT_EN) repeat counter.
// Produces a single-cycle strobe per accepted press (plus repeat strobes when enabled).
module key_debouncer
    import ship_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef SHIP_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic key,
    output logic strobe
);

    localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE_CYCLES);

    logic             meta_r;
    logic             sync_r;
    key_state_t       state_r;
    key_state_t       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             press_s;

    // Two-stage synchronizer for the asynchronous button level
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= key;
            sync_r <= meta_r;
        end
    end

    // Debounce state and stable-sample counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= RELEASED;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state; the press strobe depends only on registered state so it is glitch-free
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        press_s = 1'b0;
        case (state_r)
            RELEASED: begin
                if (sync_r) begin
                    state_s = ARMING;
                    cnt_s   = CNT_W'(1);
                end else begin
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            ARMING: begin
                if (cnt_r >= DB_LIM) begin
                    state_s = PRESSED;
                    cnt_s   = {CNT_W{1'b0}};
                    press_s = 1'b1;
                end else if (!sync_r) begin
                    state_s = RELEASED;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = sat_inc(cnt_r);
                end
            end
            PRESSED: begin
                if (!sync_r) begin
                    state_s = DISARMING;
                    cnt_s   = CNT_W'(1);
                end else begin
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            DISARMING: begin
                if (cnt_r >= DB_LIM) begin
                    state_s = RELEASED;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (sync_r) begin
                    state_s = PRESSED;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = sat_inc(cnt_r);
                end
            end
            default: begin
                state_s = RELEASED;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

`ifdef SHIP_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RP_LIM = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] rcnt_r;
    logic [CNT_W-1:0] rcnt_s;
    logic             rep_s;

    // Repeat down-counter: loaded at the press, fires on reaching 1, frozen outside PRESSED
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rcnt_r <= {CNT_W{1'b0}};
        end else begin
            rcnt_r <= rcnt_s;
        end
    end

    // Repeat strobe generation and reload
    always_comb begin
        rcnt_s = rcnt_r;
        rep_s  = 1'b0;
        if (press_s) begin
            rcnt_s = RD_LIM;
        end else if (state_r == PRESSED) begin
            if (rcnt_r <= CNT_W'(1)) begin
                rep_s  = 1'b1;
                rcnt_s = RP_LIM;
            end else begin
                rcnt_s = rcnt_r - CNT_W'(1);
            end
        end else if (state_r == RELEASED) begin
            rcnt_s = {CNT_W{1'b0}};
        end else begin
            rcnt_s = rcnt_r;
        end
    end

    assign strobe = press_s | rep_s;
`else
    assign strobe = press_s;
`endif

endmodule

// File: rtl/ship_input_conditioner.sv
// Debounces the left/right buttons, arbitrates simultaneous moves and gates on ENABLE.
// Define SHIP_AUTO_REPEAT_EN to add auto-repeat while a key is held.
module ship_input_conditioner
    import ship_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef SHIP_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic KEY_L,
    input  logic KEY_R,
    input  logic ENABLE,
    output logic L,
    output logic R
);

    logic l_stb_s;
    logic r_stb_s;
    logic l_next_s;
    logic r_next_s;

`ifdef SHIP_AUTO_REPEAT_EN
    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_key_l (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .key    (KEY_L),
        .strobe (l_stb_s)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_key_r (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .key    (KEY_R),
        .strobe (r_stb_s)
    );
`else
    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_l (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .key    (KEY_L),
        .strobe (l_stb_s)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_r (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .key    (KEY_R),
        .strobe (r_stb_s)
    );
`endif

    // Opposing strobes cancel; a strobe arriving while disabled is dropped, not queued
    always_comb begin
        l_next_s = ENABLE & l_stb_s & ~r_stb_s;
        r_next_s = ENABLE & r_stb_s & ~l_stb_s;
    end

    // Registered move pulses
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            L <= 1'b0;
            R <= 1'b0;
        end else begin
            L <= l_next_s;
            R <= r_next_s;
        end
    end

endmodule

// File: doc/ship_input_conditioner.md
Name: ship_input_conditioner

Overview:
- Upstream stage of the ship position FSM; its outputs drive that FSM's L and R inputs directly.
- Converts raw, asynchronous, bouncy left/right pushbutton levels into clean single-cycle move pulses, one pulse per press.
- Resolves simultaneous L/R pulses (no move) and gates all moves while the game is inactive.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples needed to accept a press or a release (range 1..65535).
- REPEAT_DELAY, 8: cycles from the accepted press to the first auto-repeat pulse (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 4: cycles between subsequent auto-repeat pulses (AUTO_REPEAT_EN only).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; asynchronous assert, active-low.
- KEY_L  in  1  raw left button level, active-high, asynchronous to CLK.
- KEY_R  in  1  raw right button level, active-high, asynchronous to CLK.
- ENABLE  in  1  game active; when low, L and R are held at 0.
- L  out  1  registered single-cycle move-left pulse.
- R  out  1  registered single-cycle move-right pulse.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - All synchronizer flops, counters, per-key FSMs, L and R go to 0 / RELEASED.
  - Deassertion is taken synchronously by the first CLK edge after RST_N rises.
- Synchronizer: each key passes through 2 flops; only the second-flop value (sync) is used.
- Per-key FSM, states RELEASED, ARMING, PRESSED, DISARMING; stable counter cnt is 16-bit and saturating:
  - RELEASED: on sync=1 go to ARMING, cnt=1.
  - ARMING: while sync=1, cnt increments. When cnt reaches DEBOUNCE_CYCLES, go to PRESSED and raise that key's internal press strobe for 1 cycle. If sync=0, return to RELEASED and clear cnt.
  - PRESSED: on sync=0 go to DISARMING, cnt=1.
  - DISARMING: while sync=0, cnt increments. When cnt reaches DEBOUNCE_CYCLES, go to RELEASED. If sync=1, return to PRESSED and clear cnt; no new strobe is issued.
  - DEBOUNCE_CYCLES=1: ARMING/DISARMING are still passed through, for one cycle.
- Output stage (registered, one cycle after the strobe):
  - Only L strobe: L=1.
  - Only R strobe: R=1.
  - Both strobes in the same cycle: L=R=0 (no move); both keys still enter PRESSED.
  - ENABLE=0 in the strobe cycle: that strobe is discarded, not deferred.
- Latency:
  - Raw key stable high, clean: L/R is high during the cycle after the (DEBOUNCE_CYCLES+3)th CLK edge that samples the key high.
  - Exactly one pulse per accepted press.
  - Pulses are never wider than 1 cycle.
- A key held forever produces exactly one pulse (without AUTO_REPEAT_EN).
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no pulse.
- Reset mid-debounce or mid-press: all state is discarded. A key still held after reset must be re-accepted through ARMING and produces a pulse.

Optional Feature:
- Macro: SHIP_AUTO_REPEAT_EN.
- Defined:
  - In PRESSED, a per-key repeat counter starts at the press strobe.
  - First repeat strobe at REPEAT_DELAY cycles after the press strobe, then every REPEAT_PERIOD cycles while the key remains in PRESSED.
  - Entering DISARMING freezes the repeat counter. Returning to PRESSED resumes it.
  - Entering RELEASED clears the repeat counter.
  - Repeat strobes obey the same both-keys and ENABLE rules as press strobes.
- Undefined: no repeat logic; REPEAT_DELAY and REPEAT_PERIOD are ignored.

Decomposition:
- Package ship_input_pkg:
  - enum key_state_t {RELEASED, ARMING, PRESSED, DISARMING}.
  - CNT_W=16.
  - Default constants for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
- Sub-module key_debouncer:
  - Contents: synchronizer, FSM, cnt and the optional repeat counter.
  - Outputs one strobe; instantiated twice, once for L and once for R.
- Top level: L/R arbitration, ENABLE gating and the output registers.

Test Plan:
- Reset then KEY_L=1 held 20 cycles, ENABLE=1, DEBOUNCE_CYCLES=4 -> L high for exactly 1 cycle, after edge 7; R=0 throughout.
- KEY_R bounce 1,0,1,0 (1-cycle each), then stable 1 -> no pulse during the bounce; single R pulse 7 edges after the stable-high start.
- KEY_L and KEY_R rise on the same cycle -> L=R=0 forever. KEY_L released 10 cycles, then pressed again -> one L pulse.
- ENABLE=0 during the strobe cycle -> no pulse. Key kept held with ENABLE=1 -> still no pulse; a release/press cycle yields one pulse.
- RST_N pulsed low mid-ARMING and mid-PRESSED, key held -> L=R=0 immediately on reset assert; one fresh pulse 7 edges after deassert.
- With SHIP_AUTO_REPEAT_EN, KEY_R held 30 cycles past acceptance -> R pulses at strobe+0, +8, +12, +16, +20, +24, +28 (registered one cycle later); none after release.
